fp_max_prep: RTL and testbench
==============================

# fp_max_prep

Two-stage pipelined operand-preparation stage feeding the floating-point min/max unit. It accepts raw operands with format and rounding-mode fields, applies NaN-boxing checks, then computes the 65-bit sign/magnitude extensions and 10-bit classifications. It presents a complete `fp_max_in_type` record under a valid/ready handshake, so `fp_max` stays purely combinational behind a registered boundary.

## Interface
- No parameters.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an operation.
- `in_ready`  out  1  stage can accept this cycle.
- `data1`, `data2`  in  64  raw operand registers; single precision is held in bits [31:0].
- `fmt`  in  2  format: 0 = single; any other value = double.
- `rm`  in  3  operation select: 0 = min, 1 = max; carried through unchanged.
- `out_valid`  out  1  `max_o` holds a valid operation.
- `out_ready`  in  1  downstream consumes when high together with `out_valid`.
- `max_o`  out  `fp_max_in_type`  fields: data1, data2, ext1, ext2, fmt, rm, class1, class2.

## Operation
- **S1 (register):** captures data1, data2, fmt and rm on an input transfer (`in_valid & in_ready`).
- **S2 (classify):** registers the `fp_class` results into `max_o`.
- **Single-precision data normalisation:**
  - Output data = {32'h0, data[31:0]}.
  - sign = bit 31; exponent = bits [30:23]; mantissa = bits [22:0].
- **Double-precision fields:** sign = bit 63; exponent = bits [62:52]; mantissa = bits [51:0].
- **ext:**
  - ext[64] = sign.
  - Single: ext[63:0] = {33'h0, data[30:0]}.
  - Double: ext[63:0] = {1'b0, data[62:0]}.
  - Unsigned compare of ext[63:0] orders magnitudes.
- **class (one-hot, exactly one bit set):**
  - bit 0: -inf; bit 1: -normal; bit 2: -subnormal; bit 3: -zero.
  - bit 4: +zero; bit 5: +subnormal; bit 6: +normal; bit 7: +inf.
  - bit 8: sNaN (exponent all ones, mantissa nonzero, mantissa MSB 0).
  - bit 9: qNaN (mantissa MSB 1).
- **Stage advance:**
  - S2 loads when `!s2_valid | out_ready`.
  - S1 moves into S2 when S2 loads.
  - `in_ready = !s1_valid | s2_load`.
- **Throughput:** one operation per cycle with no stall. Order is strictly preserved; no drop or duplication under any `out_ready` pattern.
- **Reset:**
  - s1_valid = s2_valid = 0; `out_valid` = 0; `in_ready` = 1 the cycle after reset.
  - All `max_o` fields are 0.
  - Reset mid-stream discards both stages.
- **`max_o` hold:** stable while `out_valid & !out_ready`.

## Timing
- Latency: input transfer at edge N, `out_valid` high after edge N+1. That is two registers: S1 at N, S2 at N+1.
- Simultaneous S2 drain and S1 refill in one cycle is allowed (full throughput).
- `in_ready` depends combinationally on `out_ready`. This is the only combinational path between ports.
- `out_valid` and `max_o` come directly from flops.

## Configuration
- **`FP_NANBOX_EN` defined:**
  - For fmt = 0 with data[63:32] != 32'hFFFFFFFF, the operand is treated as canonical qNaN.
  - Data = 64'h000000007FC00000; ext = 65'h0_000000007FC00000; class = 10'h200.
- **`FP_NANBOX_EN` undefined:** data[63:32] is ignored for single precision.

## Structure
- **fp_wire package:**
  - Existing `fp_max_in_type`.
  - New `fp_max_prep_reg_type` (S1 contents plus valid).
  - Class bit-index constants (`FP_CLASS_SNAN` = 8, `FP_CLASS_QNAN` = 9, etc.).
  - Canonical NaN constants.
- **Sub-module `fp_class`:**
  - Combinational.
  - Inputs: data, fmt. Outputs: normalised data, ext, class.
  - Instantiated twice (operand 1 and operand 2).

## Test plan
- **Double operands:** data1 = 64'h3FF0000000000000, data2 = 64'hC000000000000000, fmt = 1, rm = 0.
  - Two cycles later: ext1 = 65'h0_3FF0000000000000, ext2 = 65'h1_4000000000000000.
  - class1 = 10'h040, class2 = 10'h002, rm = 0.
- **Single sNaN and -0:** data1 = 64'hFFFFFFFF7FA00000, data2 = 64'hFFFFFFFF80000000, fmt = 0.
  - data1 out = 64'h000000007FA00000; class1 = 10'h100; class2 = 10'h008; ext2 = 65'h1_0000000000000000.
- **Improper NaN-boxing:** data1 = 64'h000000003F800000, fmt = 0.
  - With `FP_NANBOX_EN`: class1 = 10'h200, data1 out = 64'h000000007FC00000.
  - Without it: class1 = 10'h040, data1 out = 64'h000000003F800000.
- **Backpressure:** stream 4 ops (A–D) back-to-back with `out_ready` = 0 for cycles 2–4.
  - `in_ready` falls once both stages are full.
  - A–D emerge in order, each exactly once; `max_o` is stable while stalled.
- **Reset mid-stream:** both stages full, `reset` = 1 for one cycle.
  - Next cycle: `out_valid` = 0, `in_ready` = 1, `max_o` = 0; no stale op emerges afterwards.
- **Subnormal and infinity:** data1 = 64'h0000000000000001, data2 = 64'hFFF0000000000000, fmt = 1.
  - class1 = 10'h020, class2 = 10'h001.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types and constants for the floating-point min/max datapath.
package fp_wire;

    // Operand record consumed by the combinational min/max unit.
    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [64:0] ext1;
        logic [64:0] ext2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [9:0]  class1;
        logic [9:0]  class2;
    } fp_max_in_type;

    // Contents of the capture stage of fp_max_prep.
    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        valid;
    } fp_max_prep_reg_type;

    // One-hot class bit positions.
    localparam logic [3:0] FP_CLASS_NINF  = 4'd0;
    localparam logic [3:0] FP_CLASS_NNORM = 4'd1;
    localparam logic [3:0] FP_CLASS_NSUB  = 4'd2;
    localparam logic [3:0] FP_CLASS_NZERO = 4'd3;
    localparam logic [3:0] FP_CLASS_PZERO = 4'd4;
    localparam logic [3:0] FP_CLASS_PSUB  = 4'd5;
    localparam logic [3:0] FP_CLASS_PNORM = 4'd6;
    localparam logic [3:0] FP_CLASS_PINF  = 4'd7;
    localparam logic [3:0] FP_CLASS_SNAN  = 4'd8;
    localparam logic [3:0] FP_CLASS_QNAN  = 4'd9;

    // Canonical single-precision quiet NaN, as seen by the min/max unit.
    localparam logic [63:0] FP_CANON_QNAN_S       = 64'h0000_0000_7FC0_0000;
    localparam logic [64:0] FP_CANON_QNAN_S_EXT   = 65'h0_0000_0000_7FC0_0000;
    localparam logic [9:0]  FP_CANON_QNAN_S_CLASS = 10'h200;

    // Expand a class bit position into its one-hot vector.
    function automatic logic [9:0] fp_class_bit(input logic [3:0] idx);
        fp_class_bit = 10'(1) << idx;
    endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational operand classifier: normalises single-precision data,
// builds the 65-bit sign/magnitude extension and the one-hot class.
// Optional macro FP_NANBOX_EN: improperly NaN-boxed singles become canonical qNaN.
module fp_class
    import fp_wire::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  fmt,
    output logic [63:0] norm,
    output logic [64:0] ext,
    output logic [9:0]  cls
);

    logic single;
    logic sign;
    logic exp_max;
    logic exp_zero;
    logic man_zero;
    logic man_msb;

    // Field extraction per format, then class decode and NaN-box override.
    always_comb begin
        single   = (fmt == 2'd0);
        sign     = data[63];
        exp_max  = &data[62:52];
        exp_zero = ~|data[62:52];
        man_zero = ~|data[51:0];
        man_msb  = data[51];
        norm     = data;
        ext      = {data[63], 1'b0, data[62:0]};
        if (single) begin
            sign     = data[31];
            exp_max  = &data[30:23];
            exp_zero = ~|data[30:23];
            man_zero = ~|data[22:0];
            man_msb  = data[22];
            norm     = {32'h0, data[31:0]};
            ext      = {data[31], 33'h0, data[30:0]};
        end

        if (exp_max) begin
            if (man_zero)
                cls = fp_class_bit(sign ? FP_CLASS_NINF : FP_CLASS_PINF);
            else
                cls = fp_class_bit(man_msb ? FP_CLASS_QNAN : FP_CLASS_SNAN);
        end else if (exp_zero) begin
            if (man_zero)
                cls = fp_class_bit(sign ? FP_CLASS_NZERO : FP_CLASS_PZERO);
            else
                cls = fp_class_bit(sign ? FP_CLASS_NSUB : FP_CLASS_PSUB);
        end else begin
            cls = fp_class_bit(sign ? FP_CLASS_NNORM : FP_CLASS_PNORM);
        end

`ifdef FP_NANBOX_EN
        if (single && (data[63:32] != 32'hFFFF_FFFF)) begin
            norm = FP_CANON_QNAN_S;
            ext  = FP_CANON_QNAN_S_EXT;
            cls  = FP_CANON_QNAN_S_CLASS;
        end
`endif
    end

endmodule

// File: rtl/fp_max_prep.sv
// Two-stage operand preparation in front of the min/max unit: capture,
// then register classified operands into a valid/ready-framed record.
// Optional macro FP_NANBOX_EN (handled in fp_class) enables NaN-box checks.
module fp_max_prep
    import fp_wire::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   data1,
    input  logic [63:0]   data2,
    input  logic [1:0]    fmt,
    input  logic [2:0]    rm,
    output logic          out_valid,
    input  logic          out_ready,
    output fp_max_in_type max_o
);

    fp_max_prep_reg_type stage_p1;
    logic                vld_p2;
    logic                load_p2;
    fp_max_in_type       prep_p1;

    logic [63:0] norm1, norm2;
    logic [64:0] ext1, ext2;
    logic [9:0]  cls1, cls2;

    // The output stage refills whenever it is empty or being drained; the
    // capture stage can accept whenever its contents are moving on.
    assign load_p2   = !vld_p2 || out_ready;
    assign in_ready  = !stage_p1.valid || load_p2;
    assign out_valid = vld_p2;

    fp_class u_class1 (
        .data (stage_p1.data1),
        .fmt  (stage_p1.fmt),
        .norm (norm1),
        .ext  (ext1),
        .cls  (cls1)
    );

    fp_class u_class2 (
        .data (stage_p1.data2),
        .fmt  (stage_p1.fmt),
        .norm (norm2),
        .ext  (ext2),
        .cls  (cls2)
    );

    assign prep_p1 = '{
        data1:  norm1,
        data2:  norm2,
        ext1:   ext1,
        ext2:   ext2,
        fmt:    stage_p1.fmt,
        rm:     stage_p1.rm,
        class1: cls1,
        class2: cls2
    };

    // S1: capture raw operands on an input transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_p1 <= '0;
        end else if (in_ready) begin
            stage_p1.valid <= in_valid;
            if (in_valid) begin
                stage_p1.data1 <= data1;
                stage_p1.data2 <= data2;
                stage_p1.fmt   <= fmt;
                stage_p1.rm    <= rm;
            end
        end
    end

    // S2: register classified record; holds while stalled downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            max_o  <= '0;
        end else if (load_p2) begin
            vld_p2 <= stage_p1.valid;
            if (stage_p1.valid)
                max_o <= prep_p1;
        end
    end

endmodule

// File: tb/tb_fp_max_prep.sv
// Self-checking bench for fp_max_prep: directed vector table, backpressure,
// mid-stream reset and a randomized stream against a magnitude-range model.
module tb_fp_max_prep;
    import fp_wire::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   data1 = '0;
    logic [63:0]   data2 = '0;
    logic [1:0]    fmt = '0;
    logic [2:0]    rm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    fp_max_in_type max_o;

    int checks = 0;
    int errors = 0;

    fp_max_prep dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .fmt       (fmt),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_o     (max_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [1:0]  f;
        logic [2:0]  r;
    } op_t;

    typedef struct packed {
        logic [63:0] d;
        logic [64:0] e;
        logic [9:0]  c;
    } cls_t;

    typedef struct {
        string         name;
        op_t           op;
        fp_max_in_type exp;
    } vec_t;

    op_t           ops[$];
    fp_max_in_type sb[$];
    vec_t          vecs[7];

    // Reference: classify by where the magnitude falls among the format's
    // boundary values (smallest normal, infinity, smallest quiet NaN).
    function automatic cls_t classify(input logic [63:0] d, input logic [1:0] f);
        cls_t        r;
        logic        neg;
        logic [63:0] mag;
        logic [63:0] lim_norm, lim_inf, lim_qnan;
        int          idx;
        if (f == 2'd0) begin
`ifdef FP_NANBOX_EN
            if (d[63:32] != 32'hFFFF_FFFF) begin
                r.d = 64'h0000_0000_7FC0_0000;
                r.e = 65'h0_0000_0000_7FC0_0000;
                r.c = 10'h200;
                return r;
            end
`endif
            neg      = d[31];
            mag      = {33'h0, d[30:0]};
            r.d      = {32'h0, d[31:0]};
            lim_norm = 64'h0000_0000_0080_0000;
            lim_inf  = 64'h0000_0000_7F80_0000;
            lim_qnan = 64'h0000_0000_7FC0_0000;
        end else begin
            neg      = d[63];
            mag      = {1'b0, d[62:0]};
            r.d      = d;
            lim_norm = 64'h0010_0000_0000_0000;
            lim_inf  = 64'h7FF0_0000_0000_0000;
            lim_qnan = 64'h7FF8_0000_0000_0000;
        end
        r.e = {neg, mag};
        if (mag == 64'd0)          idx = neg ? 3 : 4;
        else if (mag < lim_norm)   idx = neg ? 2 : 5;
        else if (mag < lim_inf)    idx = neg ? 1 : 6;
        else if (mag == lim_inf)   idx = neg ? 0 : 7;
        else if (mag >= lim_qnan)  idx = 9;
        else                       idx = 8;
        r.c = 10'd0;
        r.c[idx] = 1'b1;
        return r;
    endfunction

    function automatic fp_max_in_type model(input op_t o);
        fp_max_in_type m;
        cls_t a, b;
        a = classify(o.d1, o.f);
        b = classify(o.d2, o.f);
        m.data1 = a.d;  m.ext1 = a.e;  m.class1 = a.c;
        m.data2 = b.d;  m.ext2 = b.e;  m.class2 = b.c;
        m.fmt = o.f;
        m.rm  = o.r;
        return m;
    endfunction

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_rec(input string name, input fp_max_in_type got, input fp_max_in_type exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_op(input logic v, input op_t o);
        in_valid = v;
        data1 = o.d1;
        data2 = o.d2;
        fmt = o.f;
        rm = o.r;
    endtask

    // Random operand biased toward zero/subnormal/inf/NaN encodings.
    function automatic logic [63:0] rand_operand(input logic [1:0] f);
        logic [63:0] d;
        int ec, mc;
        d  = {$urandom, $urandom};
        ec = int'($urandom_range(0, 3));
        mc = int'($urandom_range(0, 2));
        if (f == 2'd0) begin
            if (ec == 0) d[30:23] = 8'h00;
            if (ec == 1) d[30:23] = 8'hFF;
            if (mc == 0) d[22:0] = 23'h0;
            if ($urandom_range(0, 3) != 0) d[63:32] = 32'hFFFF_FFFF;
        end else begin
            if (ec == 0) d[62:52] = 11'h000;
            if (ec == 1) d[62:52] = 11'h7FF;
            if (mc == 0) d[51:0] = 52'h0;
        end
        return d;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.f  = 2'($urandom_range(0, 3));
        o.r  = 3'($urandom_range(0, 7));
        o.d1 = rand_operand(o.f);
        o.d2 = rand_operand(o.f);
        return o;
    endfunction

    // Stream queued ops; mode 0 = random out_ready, mode 1 = stall cycles 2-4.
    task automatic run_stream(input int mode, input int budget);
        int            cyc = 0;
        int            n_in;
        int            n_out = 0;
        logic          stall_prev = 1'b0;
        logic          saw_block = 1'b0;
        fp_max_in_type held = '0;
        op_t           idle = '0;
        n_in = ops.size();
        while ((ops.size() > 0 || sb.size() > 0) && cyc < budget) begin
            @(negedge clock);
            if (ops.size() > 0) drive_op(1'b1, ops[0]);
            else drive_op(1'b0, idle);
            if (mode == 0) out_ready = ($urandom_range(0, 2) != 0);
            else           out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (stall_prev) begin
                chk_bit("hold_valid", out_valid, 1'b1);
                chk_rec("hold_data", max_o, held);
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got %h expected none", max_o);
                end else begin
                    chk_rec("stream_out", max_o, sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ops[0]));
                void'(ops.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held = max_o;
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        drive_op(1'b0, idle);
        checks++;
        if (ops.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: got %0d pending expected 0", ops.size() + sb.size());
        end
        checks++;
        if (n_out != n_in) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs expected %0d", n_out, n_in);
        end
        if (mode == 1) chk_bit("in_ready_fell", saw_block, 1'b1);
        ops.delete();
        sb.delete();
    endtask

    initial begin
        op_t o;
        op_t idle = '0;

        vecs[0] = '{"dbl_norm", '{64'h3FF0000000000000, 64'hC000000000000000, 2'd1, 3'd0},
                    '{64'h3FF0000000000000, 64'hC000000000000000,
                      65'h0_3FF0000000000000, 65'h1_4000000000000000, 2'd1, 3'd0, 10'h040, 10'h002}};
        vecs[1] = '{"sgl_snan_nzero", '{64'hFFFFFFFF7FA00000, 64'hFFFFFFFF80000000, 2'd0, 3'd1},
                    '{64'h000000007FA00000, 64'h0000000080000000,
                      65'h0_000000007FA00000, 65'h1_0000000000000000, 2'd0, 3'd1, 10'h100, 10'h008}};
`ifdef FP_NANBOX_EN
        vecs[2] = '{"sgl_nanbox", '{64'h000000003F800000, 64'hFFFFFFFF3F800000, 2'd0, 3'd2},
                    '{64'h000000007FC00000, 64'h000000003F800000,
                      65'h0_000000007FC00000, 65'h0_000000003F800000, 2'd0, 3'd2, 10'h200, 10'h040}};
`else
        vecs[2] = '{"sgl_nanbox", '{64'h000000003F800000, 64'hFFFFFFFF3F800000, 2'd0, 3'd2},
                    '{64'h000000003F800000, 64'h000000003F800000,
                      65'h0_000000003F800000, 65'h0_000000003F800000, 2'd0, 3'd2, 10'h040, 10'h040}};
`endif
        vecs[3] = '{"dbl_sub_ninf", '{64'h0000000000000001, 64'hFFF0000000000000, 2'd1, 3'd7},
                    '{64'h0000000000000001, 64'hFFF0000000000000,
                      65'h0_0000000000000001, 65'h1_7FF0000000000000, 2'd1, 3'd7, 10'h020, 10'h001}};
        vecs[4] = '{"fmt2_nans", '{64'h7FF8000000000000, 64'h7FF0000000000001, 2'd2, 3'd5},
                    '{64'h7FF8000000000000, 64'h7FF0000000000001,
                      65'h0_7FF8000000000000, 65'h0_7FF0000000000001, 2'd2, 3'd5, 10'h200, 10'h100}};
        vecs[5] = '{"sgl_pinf_nnorm", '{64'hFFFFFFFF7F800000, 64'hFFFFFFFFBF800000, 2'd0, 3'd0},
                    '{64'h000000007F800000, 64'h00000000BF800000,
                      65'h0_000000007F800000, 65'h1_000000003F800000, 2'd0, 3'd0, 10'h080, 10'h002}};
        vecs[6] = '{"dbl_nsub_pzero", '{64'h800000000000000F, 64'h0000000000000000, 2'd3, 3'd4},
                    '{64'h800000000000000F, 64'h0000000000000000,
                      65'h1_000000000000000F, 65'h0_0000000000000000, 2'd3, 3'd4, 10'h004, 10'h010}};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_rec("rst_max_o", max_o, '0);

        // Directed vectors with exact two-edge latency
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            drive_op(1'b1, vecs[i].op);
            out_ready = 1'b1;
            #1;
            chk_bit({vecs[i].name, "_in_ready"}, in_ready, 1'b1);
            @(posedge clock);
            @(negedge clock);
            drive_op(1'b0, idle);
            #1;
            chk_bit({vecs[i].name, "_early"}, out_valid, 1'b0);
            @(posedge clock);
            @(negedge clock);
            #1;
            chk_bit({vecs[i].name, "_valid"}, out_valid, 1'b1);
            chk_rec(vecs[i].name, max_o, vecs[i].exp);
            @(posedge clock);
        end

        // Backpressure: four ops, out_ready low for cycles 2-4
        for (int i = 0; i < 4; i++) ops.push_back(rand_op());
        run_stream(1, 100);

        // Reset with both stages full
        @(negedge clock);
        out_ready = 1'b0;
        drive_op(1'b1, rand_op());
        @(posedge clock);
        @(negedge clock);
        drive_op(1'b1, rand_op());
        @(posedge clock);
        @(negedge clock);
        drive_op(1'b0, idle);
        #1;
        chk_bit("full_out_valid", out_valid, 1'b1);
        chk_bit("full_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_rec("midrst_max_o", max_o, '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            chk_bit("midrst_no_stale", out_valid, 1'b0);
        end

        // Randomized stream
        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            ops.push_back(o);
        end
        run_stream(0, 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
